// File: rtl/ascon_pack.sv
// Shared ASCON definitions: sequencer state, round schedule bounds
// and the round-constant helper used by the round logic.
package ascon_pack;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } round_state_t;

  localparam int unsigned ROUND_PA_INIT = 0;
  localparam int unsigned ROUND_PB_INIT = 6;
  localparam int unsigned ROUND_LAST    = 11;

  // Upper nibble counts down while the lower nibble counts up.
  function automatic logic [7:0] round_const(
    input logic [3:0] idx
  );
    round_const = {4'hF - idx, idx};
  endfunction

endpackage

// File: rtl/ascon_round_counter.sv
// ASCON permutation round sequencer: loads a p^a or p^b start index
// and steps to the terminal round under an enable/stall input.
module ascon_round_counter
  import ascon_pack::*;
#(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned INIT_A = ROUND_PA_INIT,
  parameter int unsigned INIT_B = ROUND_PB_INIT,
  parameter int unsigned LAST   = ROUND_LAST
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic             sel_i,
  input  logic             en_i,
  output logic             ready_o,
  output logic             busy_o,
  output logic [WIDTH-1:0] round_o,
  output logic [7:0]       const_o,
  output logic             last_o,
  output logic             done_o
);

  localparam logic [WIDTH-1:0] W_INIT_A = WIDTH'(INIT_A);
  localparam logic [WIDTH-1:0] W_INIT_B = WIDTH'(INIT_B);
  localparam logic [WIDTH-1:0] W_LAST   = WIDTH'(LAST);

  if ((INIT_A > LAST) || (INIT_B > LAST) ||
      (LAST >= (64'd1 << WIDTH))) begin : g_bad_params
    $error("ascon_round_counter: bad round parameters");
  end

  round_state_t     r_state;
  logic [WIDTH-1:0] r_round;
  logic             r_done;

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      r_state <= IDLE;
      r_round <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (start_i) begin
            r_round <= sel_i ? W_INIT_B : W_INIT_A;
            r_state <= RUN;
          end
        end
        RUN: begin
          if (en_i) begin
            if (r_round == W_LAST) begin
              r_state <= IDLE;
              r_done  <= 1'b1;
            end else begin
              r_round <= r_round + 1'b1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  logic       w_busy;
  logic [3:0] w_idx;

  assign w_busy  = (r_state == RUN);
  assign w_idx   = 4'(r_round);

  assign ready_o = ~w_busy;
  assign busy_o  = w_busy;
  assign round_o = r_round;
  assign const_o = round_const(w_idx);
  assign last_o  = w_busy & (r_round == W_LAST);
  assign done_o  = r_done;

endmodule

// File: tb/tb_ascon_round_counter.sv
// Directed bench for ascon_round_counter: reset, p^a, stalled p^b,
// ignored start, back-to-back and mid-run reset.
module tb_ascon_round_counter;

  logic       clk;
  logic       rst;
  logic       start;
  logic       sel;
  logic       en;
  logic       ready;
  logic       busy;
  logic [3:0] round;
  logic [7:0] rc;
  logic       last;
  logic       done;

  int vectors;
  int miscompares;

  ascon_round_counter #(
    .WIDTH (4),
    .INIT_A(0),
    .INIT_B(6),
    .LAST  (11)
  ) dut (
    .clock_i(clk),
    .reset_i(rst),
    .start_i(start),
    .sel_i  (sel),
    .en_i   (en),
    .ready_o(ready),
    .busy_o (busy),
    .round_o(round),
    .const_o(rc),
    .last_o (last),
    .done_o (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] rc_tab [0:11] = '{
    8'hF0, 8'hE1, 8'hD2, 8'hC3, 8'hB4, 8'hA5,
    8'h96, 8'h87, 8'h78, 8'h69, 8'h5A, 8'h4B
  };

  logic [3:0] pb_round [0:9] = '{
    4'd6, 4'd7, 4'd7, 4'd7, 4'd8,
    4'd9, 4'd9, 4'd9, 4'd10, 4'd11
  };
  logic pb_en [0:9] = '{
    1'b1, 1'b0, 1'b0, 1'b1, 1'b1,
    1'b0, 1'b0, 1'b1, 1'b1, 1'b1
  };

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag, input logic [3:0] r);
    chk({tag, "_ready"}, 32'(ready), 32'd1);
    chk({tag, "_busy"},  32'(busy),  32'd0);
    chk({tag, "_round"}, 32'(round), 32'(r));
  endtask

  int dones;

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst   = 1'b1;
    start = 1'b0;
    sel   = 1'b0;
    en    = 1'b0;
    tick();
    rst = 1'b0;
    tick();

    // reset state, held while idle
    for (int i = 0; i < 3; i++) begin
      chk_idle("rst", 4'd0);
      chk("rst_const", 32'(rc),   32'hF0);
      chk("rst_last",  32'(last), 32'd0);
      chk("rst_done",  32'(done), 32'd0);
      tick();
    end

    // p^a run
    start = 1'b1;
    sel   = 1'b0;
    en    = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      chk("pa_round", 32'(round), 32'(i));
      chk("pa_busy",  32'(busy),  32'd1);
      chk("pa_const", 32'(rc),    32'(rc_tab[i]));
      chk("pa_last",  32'(last),  32'(i == 11));
      chk("pa_done",  32'(done),  32'd0);
      tick();
    end
    chk_idle("pa_end", 4'd11);
    chk("pa_done_pulse", 32'(done), 32'd1);
    tick();
    chk("pa_done_clr", 32'(done), 32'd0);
    chk("pa_hold", 32'(round), 32'd11);

    // p^b run with stalls on rounds 7 and 9
    start = 1'b1;
    sel   = 1'b1;
    tick();
    start = 1'b0;
    sel   = 1'b0;
    for (int c = 0; c < 10; c++) begin
      en = pb_en[c];
      chk("pb_round", 32'(round), 32'(pb_round[c]));
      chk("pb_busy",  32'(busy),  32'd1);
      chk("pb_done",  32'(done),  32'd0);
      tick();
    end
    en = 1'b1;
    chk_idle("pb_end", 4'd11);
    chk("pb_done_pulse", 32'(done), 32'd1);

    // back-to-back start during the done cycle
    start = 1'b1;
    sel   = 1'b1;
    tick();
    start = 1'b0;
    sel   = 1'b0;
    chk("b2b_round", 32'(round), 32'd6);
    chk("b2b_busy",  32'(busy),  32'd1);
    chk("b2b_done",  32'(done),  32'd0);
    for (int i = 0; i < 6; i++) tick();
    chk("b2b_done_pulse", 32'(done), 32'd1);
    tick();

    // start in RUN is ignored
    start = 1'b1;
    sel   = 1'b0;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    chk("ign_at3", 32'(round), 32'd3);
    start = 1'b1;
    sel   = 1'b1;
    tick();
    start = 1'b0;
    sel   = 1'b0;
    dones = 0;
    for (int r = 4; r < 12; r++) begin
      chk("ign_round", 32'(round), 32'(r));
      if (done) dones++;
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      if (done) dones++;
      tick();
    end
    chk("ign_dones", 32'(dones), 32'd1);

    // reset mid-run at round 5
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("mr_at5", 32'(round), 32'd5);
    rst = 1'b1;
    #1;
    chk_idle("mr_async", 4'd0);
    chk("mr_done", 32'(done), 32'd0);
    tick();
    rst = 1'b0;
    dones = 0;
    for (int i = 0; i < 15; i++) begin
      if (done) dones++;
      tick();
    end
    chk("mr_no_done", 32'(dones), 32'd0);
    chk_idle("mr_idle", 4'd0);

    // fresh p^b completes after the abort
    start = 1'b1;
    sel   = 1'b1;
    tick();
    start = 1'b0;
    dones = 0;
    for (int i = 0; i < 20 && dones == 0; i++) begin
      if (done) dones++;
      else tick();
    end
    chk("mr_new_done", 32'(dones), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
